// File: rtl/branch_cond_unit.sv
// ---------------------------------------------------------------------------
// branch_cond_unit
//
// Evaluates a branch condition code against the Z/N/V status flags and
// returns a registered taken/not-taken decision together with the next PC.
// Flags written by the ALU in the same cycle are forwarded ahead of the
// status register, so a compare followed directly by a branch needs no stall.
// A single response register forms a one-deep valid/ready pipeline stage.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   z_in, n_in, v_in           flags from the status register
//   flag_upd_en                ALU writes the flags this cycle
//   z_upd, n_upd, v_upd        flag values being written by the ALU
//   req_valid / req_ready      request handshake
//   req_cond                   4-bit condition code (12..15 reserved)
//   req_pc, req_offset         branch PC and signed byte offset
//   resp_valid / resp_ready    response handshake
//   resp_taken                 branch taken
//   resp_target                next PC
//   resp_illegal               reserved condition code seen
//   flush                      drops the held response and any offered request
//   taken_cnt                  saturating count of consumed taken responses
// ---------------------------------------------------------------------------
module branch_cond_unit #(
   parameter int ADDR_W = 32,
   parameter int PC_INC = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              z_in,
   input  logic              n_in,
   input  logic              v_in,
   input  logic              flag_upd_en,
   input  logic              z_upd,
   input  logic              n_upd,
   input  logic              v_upd,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_cond,
   input  logic [ADDR_W-1:0] req_pc,
   input  logic [ADDR_W-1:0] req_offset,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_taken,
   output logic [ADDR_W-1:0] resp_target,
   output logic              resp_illegal,
   input  logic              flush,
   output logic [CNT_W-1:0]  taken_cnt
);

   localparam logic [3:0] COND_EQ = 4'd0;
   localparam logic [3:0] COND_NE = 4'd1;
   localparam logic [3:0] COND_LT = 4'd2;
   localparam logic [3:0] COND_GE = 4'd3;
   localparam logic [3:0] COND_GT = 4'd4;
   localparam logic [3:0] COND_LE = 4'd5;
   localparam logic [3:0] COND_MI = 4'd6;
   localparam logic [3:0] COND_PL = 4'd7;
   localparam logic [3:0] COND_VS = 4'd8;
   localparam logic [3:0] COND_VC = 4'd9;
   localparam logic [3:0] COND_AL = 4'd10;
   localparam logic [3:0] COND_NV = 4'd11;

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   // Returns {illegal, taken}; reserved codes are never taken.
   function automatic logic [1:0] cond_eval(input logic [3:0] cond,
                                            input logic z,
                                            input logic n,
                                            input logic v);
      logic lt;
      logic [1:0] res;
      lt  = n ^ v;
      res = 2'b00;
      case (cond)
         COND_EQ: res = {1'b0, z};
         COND_NE: res = {1'b0, ~z};
         COND_LT: res = {1'b0, lt};
         COND_GE: res = {1'b0, ~lt};
         COND_GT: res = {1'b0, ~z & ~lt};
         COND_LE: res = {1'b0, z | lt};
         COND_MI: res = {1'b0, n};
         COND_PL: res = {1'b0, ~n};
         COND_VS: res = {1'b0, v};
         COND_VC: res = {1'b0, ~v};
         COND_AL: res = 2'b01;
         COND_NV: res = 2'b00;
         default: res = 2'b10;
      endcase
      return res;
   endfunction

   // Offset is two's complement; adding its raw bits gives the modulo-2^ADDR_W
   // target, so wrap-around in either direction is silent.
   function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc,
                                                 input logic signed [ADDR_W-1:0] off,
                                                 input logic taken);
      return taken ? (pc + $unsigned(off)) : (pc + PC_STEP);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + 1'b1;
   endfunction

   logic                     z_eff;
   logic                     n_eff;
   logic                     v_eff;
   logic [1:0]               dec_p0;
   logic signed [ADDR_W-1:0] off_p0;
   logic [ADDR_W-1:0]        target_p0;
   logic                     accept;
   logic                     consume;

   logic                     vld_p1;
   logic                     taken_p1;
   logic                     illegal_p1;
   logic [ADDR_W-1:0]        target_p1;
   logic [CNT_W-1:0]         cnt_p1;

   // Stage p0: flag forwarding, condition decode and target calculation
   assign z_eff     = flag_upd_en ? z_upd : z_in;
   assign n_eff     = flag_upd_en ? n_upd : n_in;
   assign v_eff     = flag_upd_en ? v_upd : v_in;
   assign dec_p0    = cond_eval(req_cond, z_eff, n_eff, v_eff);
   assign off_p0    = req_offset;
   assign target_p0 = next_pc(req_pc, off_p0, dec_p0[0]);

   assign req_ready = ~vld_p1 | resp_ready;
   assign accept    = req_valid & req_ready & ~flush;
   assign consume   = vld_p1 & resp_ready;

   // Stage p1: response register; flush overrides both accept and consume
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1     <= 1'b0;
         taken_p1   <= 1'b0;
         illegal_p1 <= 1'b0;
         target_p1  <= '0;
      end else if (flush) begin
         vld_p1     <= 1'b0;
      end else if (accept) begin
         vld_p1     <= 1'b1;
         taken_p1   <= dec_p0[0];
         illegal_p1 <= dec_p0[1];
         target_p1  <= target_p0;
      end else if (consume) begin
         vld_p1     <= 1'b0;
      end
   end

   // A response flushed in its consume cycle is not counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_p1 <= '0;
      end else if (consume & taken_p1 & ~flush) begin
         cnt_p1 <= sat_inc(cnt_p1);
      end
   end

   assign resp_valid   = vld_p1;
   assign resp_taken   = taken_p1;
   assign resp_illegal = illegal_p1;
   assign resp_target  = target_p1;
   assign taken_cnt    = cnt_p1;

endmodule

// File: tb/tb_branch_cond_unit.sv
module tb_branch_cond_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        z_in = 1'b0, n_in = 1'b0, v_in = 1'b0;
   logic        flag_upd_en = 1'b0, z_upd = 1'b0, n_upd = 1'b0, v_upd = 1'b0;
   logic        req_valid = 1'b0;
   logic [3:0]  req_cond = 4'd0;
   logic [31:0] req_pc = '0, req_offset = '0;
   logic        resp_ready = 1'b0;
   logic        flush = 1'b0;

   logic        req_ready, resp_valid, resp_taken, resp_illegal;
   logic [31:0] resp_target;
   logic [15:0] taken_cnt;

   logic        r2_ready, v2, t2, i2;
   logic [31:0] tg2;
   logic [1:0]  cnt2;

   always #5 clk = ~clk;

   branch_cond_unit dut (
      .clk(clk), .rst_n(rst_n), .z_in(z_in), .n_in(n_in), .v_in(v_in),
      .flag_upd_en(flag_upd_en), .z_upd(z_upd), .n_upd(n_upd), .v_upd(v_upd),
      .req_valid(req_valid), .req_ready(req_ready), .req_cond(req_cond),
      .req_pc(req_pc), .req_offset(req_offset), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_taken(resp_taken), .resp_target(resp_target),
      .resp_illegal(resp_illegal), .flush(flush), .taken_cnt(taken_cnt));

   branch_cond_unit #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .z_in(z_in), .n_in(n_in), .v_in(v_in),
      .flag_upd_en(flag_upd_en), .z_upd(z_upd), .n_upd(n_upd), .v_upd(v_upd),
      .req_valid(req_valid), .req_ready(r2_ready), .req_cond(req_cond),
      .req_pc(req_pc), .req_offset(req_offset), .resp_valid(v2),
      .resp_ready(resp_ready), .resp_taken(t2), .resp_target(tg2),
      .resp_illegal(i2), .flush(flush), .taken_cnt(cnt2));

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: one-slot response holder plus counters
   logic        m_valid = 1'b0, m_taken = 1'b0, m_ill = 1'b0;
   logic [31:0] m_tgt = '0;
   int          m_cnt = 0, m_cnt2 = 0;

   typedef struct {
      logic [3:0]  cond;
      logic        z, n, v, upd, zu, nu, vu;
      logic [31:0] pc, off;
      logic        tk;
      logic [31:0] tgt;
      logic        ill;
   } vec_t;
   vec_t vecs[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Branch semantics in signed-compare terms: N/V describe a - b.
   function automatic logic [1:0] ref_dec(input logic [3:0] c, input logic z, input logic n, input logic v);
      logic less;
      less = (n != v);
      if (c > 4'd11) return 2'b10;
      case (c)
         4'd0:  return {1'b0, z == 1'b1};
         4'd1:  return {1'b0, z == 1'b0};
         4'd2:  return {1'b0, less};
         4'd3:  return {1'b0, !less};
         4'd4:  return {1'b0, !less && !z};
         4'd5:  return {1'b0, less || z};
         4'd6:  return {1'b0, n == 1'b1};
         4'd7:  return {1'b0, n == 1'b0};
         4'd8:  return {1'b0, v == 1'b1};
         4'd9:  return {1'b0, v == 1'b0};
         4'd10: return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   task automatic tick();
      logic ready, acc, cons, fz, fn, fv;
      logic [1:0] d;
      #1;
      ready = !m_valid || resp_ready;
      chk("req_ready", {63'd0, req_ready}, {63'd0, ready});
      acc  = req_valid && ready && !flush;
      cons = m_valid && resp_ready;
      if (cons && m_taken && !flush) begin
         m_cnt  = (m_cnt  < 65535) ? m_cnt + 1 : m_cnt;
         m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
      end
      fz = flag_upd_en ? z_upd : z_in;
      fn = flag_upd_en ? n_upd : n_in;
      fv = flag_upd_en ? v_upd : v_in;
      if (flush) m_valid = 1'b0;
      else if (acc) begin
         d = ref_dec(req_cond, fz, fn, fv);
         m_valid = 1'b1;
         m_taken = d[0];
         m_ill   = d[1];
         m_tgt   = req_pc + (d[0] ? req_offset : 32'd4);
      end else if (cons) m_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("resp_valid",   {63'd0, resp_valid},   {63'd0, m_valid});
      chk("resp_taken",   {63'd0, resp_taken},   {63'd0, m_taken});
      chk("resp_illegal", {63'd0, resp_illegal}, {63'd0, m_ill});
      chk("resp_target",  {32'd0, resp_target},  {32'd0, m_tgt});
      chk("taken_cnt",    {48'd0, taken_cnt},    64'(m_cnt));
      chk("taken_cnt2",   {62'd0, cnt2},         64'(m_cnt2));
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_taken = 1'b0; m_ill = 1'b0; m_tgt = '0;
      m_cnt = 0; m_cnt2 = 0;
   endtask

   task automatic set_req(input logic [3:0] c, input logic [31:0] pc, input logic [31:0] off);
      req_valid = 1'b1; req_cond = c; req_pc = pc; req_offset = off;
   endtask

   initial begin
      logic [31:0] cnt_before;
      int sat_exp[5];
      sat_exp = '{1, 2, 3, 3, 3};

      //          cond  z     n     v     upd   zu    nu    vu    pc            off           tk    tgt           ill
      vecs[0]  = '{4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100,      32'h20,       1'b1, 32'h120,      1'b0};
      vecs[1]  = '{4'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40,       32'h100,      1'b0, 32'h44,       1'b0};
      vecs[2]  = '{4'd2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h8,        1'b0, 32'h0,        1'b0};
      vecs[3]  = '{4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h50,       32'hFFFFFFF0, 1'b1, 32'h40,       1'b0};
      vecs[4]  = '{4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200,      32'h40,       1'b0, 32'h204,      1'b1};
      vecs[5]  = '{4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000,     32'h10,       1'b1, 32'h1010,     1'b0};
      vecs[6]  = '{4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80,       32'h8,        1'b0, 32'h84,       1'b0};
      vecs[7]  = '{4'd6,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'hFFFFFFFC, 1'b1, 32'hFFFFFFFC, 1'b0};
      vecs[8]  = '{4'd9,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10,       32'h20,       1'b0, 32'h14,       1'b0};
      vecs[9]  = '{4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFF0, 32'h20,       1'b1, 32'h10,       1'b0};
      vecs[10] = '{4'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h30,       32'h40,       1'b0, 32'h34,       1'b0};
      vecs[11] = '{4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h60,       32'h4,        1'b0, 32'h64,       1'b1};
      vecs[12] = '{4'd8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        1'b1, 32'h8,        1'b0};
      vecs[13] = '{4'd7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h70,       32'h30,       1'b1, 32'hA0,       1'b0};

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid",   {63'd0, resp_valid},   64'd0);
      chk("rst_taken",   {63'd0, resp_taken},   64'd0);
      chk("rst_target",  {32'd0, resp_target},  64'd0);
      chk("rst_illegal", {63'd0, resp_illegal}, 64'd0);
      chk("rst_cnt",     {48'd0, taken_cnt},    64'd0);
      chk("rst_ready",   {63'd0, req_ready},    64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Table-driven single transactions
      resp_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         z_in = vecs[i].z; n_in = vecs[i].n; v_in = vecs[i].v;
         flag_upd_en = vecs[i].upd; z_upd = vecs[i].zu; n_upd = vecs[i].nu; v_upd = vecs[i].vu;
         set_req(vecs[i].cond, vecs[i].pc, vecs[i].off);
         tick();
         req_valid = 1'b0; flag_upd_en = 1'b0;
         z_in = ~vecs[i].z; n_in = ~vecs[i].n; v_in = ~vecs[i].v;
         chk($sformatf("vec%0d_valid", i),   {63'd0, resp_valid},   64'd1);
         chk($sformatf("vec%0d_taken", i),   {63'd0, resp_taken},   {63'd0, vecs[i].tk});
         chk($sformatf("vec%0d_target", i),  {32'd0, resp_target},  {32'd0, vecs[i].tgt});
         chk($sformatf("vec%0d_illegal", i), {63'd0, resp_illegal}, {63'd0, vecs[i].ill});
         tick();
         if (i == 0) chk("first_cnt", {48'd0, taken_cnt}, 64'd1);
      end

      // Stall for three cycles, then back-to-back throughput
      set_req(4'd10, 32'h300, 32'h10);
      tick();
      resp_ready = 1'b0;
      set_req(4'd0, 32'h400, 32'h4);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_ready",  {63'd0, req_ready},   64'd0);
         chk("stall_target", {32'd0, resp_target}, 64'h310);
      end
      resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_req(4'd10, 32'h600 + 32'(16 * i), 32'h0);
         tick();
         chk("b2b_valid",  {63'd0, resp_valid},  64'd1);
         chk("b2b_target", {32'd0, resp_target}, 64'(32'h600 + 32'(16 * i)));
      end
      req_valid = 1'b0;
      tick();

      // Flush while FULL with a request offered
      set_req(4'd10, 32'h700, 32'h8);
      tick();
      cnt_before = 32'(m_cnt);
      flush = 1'b1;
      set_req(4'd10, 32'h800, 32'h8);
      tick();
      chk("flush_valid", {63'd0, resp_valid}, 64'd0);
      chk("flush_cnt",   {48'd0, taken_cnt},  {32'd0, cnt_before});
      flush = 1'b0; req_valid = 1'b0;
      tick();
      chk("flush_dropped", {63'd0, resp_valid}, 64'd0);

      // Asynchronous reset in the middle of a held response
      set_req(4'd10, 32'h500, 32'h24);
      tick();
      req_valid = 1'b0; resp_ready = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid",   {63'd0, resp_valid},   64'd0);
      chk("arst_taken",   {63'd0, resp_taken},   64'd0);
      chk("arst_target",  {32'd0, resp_target},  64'd0);
      chk("arst_illegal", {63'd0, resp_illegal}, 64'd0);
      chk("arst_cnt",     {48'd0, taken_cnt},    64'd0);
      chk("arst_ready",   {63'd0, req_ready},    64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Counter saturation on the 2-bit instance
      resp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_req(4'd10, 32'h900, 32'h4);
         tick();
         req_valid = 1'b0;
         tick();
         chk($sformatf("sat_cnt%0d", i), {62'd0, cnt2}, 64'(sat_exp[i]));
      end

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         z_in = 1'($urandom); n_in = 1'($urandom); v_in = 1'($urandom);
         flag_upd_en = 1'($urandom);
         z_upd = 1'($urandom); n_upd = 1'($urandom); v_upd = 1'($urandom);
         req_valid  = ($urandom_range(0, 9) < 7);
         resp_ready = ($urandom_range(0, 9) < 7);
         flush      = ($urandom_range(0, 15) == 0);
         req_cond   = 4'($urandom_range(0, 15));
         req_pc     = $urandom;
         req_offset = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 512)) - 256);
         tick();
      end
      req_valid = 1'b0; flush = 1'b0; flag_upd_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
